// File: rtl/demod_pkg.sv
// ---------------------------------------------------------------------------
// demod_pkg
// Shared types and width constants for the AM/ASK demodulation path.
//   mode_t  : decided modulation mode published to the mode-select mux
//   state_t : measurement sequencer states of demod_window_ctrl
//   *_DEF   : default widths used by the envelope path blocks
// ---------------------------------------------------------------------------
package demod_pkg;

    localparam int ENV_W_DEF      = 14;
    localparam int WIN_LOG2_DEF   = 10;
    localparam int SIG_THRESH_DEF = 64;
    localparam int MID_SHIFT_DEF  = 3;
    localparam int MODE_W         = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_NONE = 2'd0,
        MODE_AM   = 2'd1,
        MODE_ASK  = 2'd2
    } mode_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACQ    = 3'd1,
        S_THR    = 3'd2,
        S_CLS    = 3'd3,
        S_DECIDE = 3'd4
    } state_t;

endpackage

// File: rtl/demod_window_ctrl_win_minmax.sv
// ---------------------------------------------------------------------------
// win_minmax
// Clamps a signed envelope sample to a non-negative magnitude and tracks the
// running maximum and minimum of that magnitude over a window.
//   clk        : system clock
//   sample_vld : accept the current sample into the running extremes
//   first      : with sample_vld, load both extremes from this sample
//   env_in     : signed envelope sample
//   mag        : combinational clamped magnitude max(env_in, 0)
//   max_val    : running maximum
//   min_val    : running minimum
// ---------------------------------------------------------------------------
module win_minmax #(
    parameter int ENV_W = 14
) (
    input  logic             clk,
    input  logic             sample_vld,
    input  logic             first,
    input  logic [ENV_W-1:0] env_in,
    output logic [ENV_W-1:0] mag,
    output logic [ENV_W-1:0] max_val,
    output logic [ENV_W-1:0] min_val
);

    function automatic logic [ENV_W-1:0] clamp_pos(input logic signed [ENV_W-1:0] v);
        if (v < 0) return '0;
        return $unsigned(v);
    endfunction

    logic signed [ENV_W-1:0] env_s;

    assign env_s = env_in;
    assign mag   = clamp_pos(env_s);

    // Extremes are pure data: the load-first control makes a reset redundant.
    always_ff @(posedge clk) begin
        if (sample_vld) begin
            if (first) begin
                max_val <= mag;
                min_val <= mag;
            end else begin
                if (mag > max_val) max_val <= mag;
                if (mag < min_val) min_val <= mag;
            end
        end
    end

endmodule

// File: rtl/demod_window_ctrl.sv
// ---------------------------------------------------------------------------
// demod_window_ctrl
// Two-window envelope classifier: window 1 (ACQ) acquires the envelope
// extremes, THR derives quarter-spread thresholds, window 2 (CLS) counts
// mid-band samples, DECIDE publishes NONE / AM / ASK plus the extremes.
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : begin one sequence (IDLE only)
//   auto_run    : restart acquisition after every decision
//   abort       : return to IDLE, published results untouched
//   env_valid   : env_in qualifier
//   env_in      : signed envelope sample
//   busy        : sequencer not in IDLE
//   done        : one-cycle pulse when a decision is registered
//   mode        : 0 NONE, 1 AM, 2 ASK
//   mode_valid  : a decision has been made since reset
//   env_max/min : extremes of the last completed acquisition window
// ---------------------------------------------------------------------------
module demod_window_ctrl
    import demod_pkg::*;
#(
    parameter int ENV_W      = ENV_W_DEF,
    parameter int WIN_LOG2   = WIN_LOG2_DEF,
    parameter int SIG_THRESH = SIG_THRESH_DEF,
    parameter int MID_SHIFT  = MID_SHIFT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             auto_run,
    input  logic             abort,
    input  logic             env_valid,
    input  logic [ENV_W-1:0] env_in,
    output logic             busy,
    output logic             done,
    output logic [1:0]       mode,
    output logic             mode_valid,
    output logic [ENV_W-1:0] env_max,
    output logic [ENV_W-1:0] env_min
);

    localparam int                WIN_LEN   = 1 << WIN_LOG2;
    localparam logic [WIN_LOG2:0] ASK_LIMIT = (WIN_LOG2+1)'(WIN_LEN >> MID_SHIFT);
    localparam logic [ENV_W-1:0]  SIG_LIM   = ENV_W'(SIG_THRESH);

    state_t              state, state_nxt;
    mode_t               mode_q;
    logic [WIN_LOG2-1:0] win_cnt;
    logic [WIN_LOG2:0]   mid_cnt;
    logic [ENV_W-1:0]    thr_lo, thr_hi, q_spread;
    logic [ENV_W-1:0]    mag, run_max, run_min;
    logic                win_last, acq_vld, in_band;

    function automatic mode_t classify(input logic [ENV_W-1:0] mx, input logic [WIN_LOG2:0] cnt);
        if (mx < SIG_LIM)    return MODE_NONE;
        if (cnt < ASK_LIMIT) return MODE_ASK;
        return MODE_AM;
    endfunction

    // The window counter wraps back to zero on the final sample, so it is
    // already cleared for the next window without an explicit reload.
    assign win_last = (win_cnt == '1);
    assign acq_vld  = (state == S_ACQ) && env_valid && !abort;
    assign in_band  = (mag > thr_lo) && (mag < thr_hi);
    assign q_spread = (run_max - run_min) >> 2;
    assign busy     = (state != S_IDLE);
    assign mode     = mode_q;

    win_minmax #(.ENV_W(ENV_W)) u_minmax (
        .clk        (clk),
        .sample_vld (acq_vld),
        .first      (win_cnt == '0),
        .env_in     (env_in),
        .mag        (mag),
        .max_val    (run_max),
        .min_val    (run_min)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start || auto_run)     state_nxt = S_ACQ;
            S_ACQ:    if (env_valid && win_last) state_nxt = S_THR;
            S_THR:                               state_nxt = S_CLS;
            S_CLS:    if (env_valid && win_last) state_nxt = S_DECIDE;
            S_DECIDE:                            state_nxt = auto_run ? S_ACQ : S_IDLE;
            default:                             state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            win_cnt    <= '0;
            mid_cnt    <= '0;
            done       <= 1'b0;
            mode_q     <= MODE_NONE;
            mode_valid <= 1'b0;
            env_max    <= '0;
            env_min    <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            if (abort) begin
                win_cnt <= '0;
                mid_cnt <= '0;
            end else begin
                if ((state == S_ACQ || state == S_CLS) && env_valid)
                    win_cnt <= win_cnt + WIN_LOG2'(1);
                if (state == S_THR)
                    mid_cnt <= '0;
                if (state == S_CLS && env_valid && in_band)
                    mid_cnt <= mid_cnt + (WIN_LOG2+1)'(1);
                if (state == S_DECIDE) begin
                    mode_q     <= classify(run_max, mid_cnt);
                    env_max    <= run_max;
                    env_min    <= run_min;
                    mode_valid <= 1'b1;
                    done       <= 1'b1;
                end
            end
        end
    end

    // Thresholds: min <= lo <= hi <= max, so no wrap is possible.
    always_ff @(posedge clk) begin
        if (state == S_THR) begin
            thr_lo <= run_min + q_spread;
            thr_hi <= run_max - q_spread;
        end
    end

endmodule

// File: doc/demod_window_ctrl.md
# demod_window_ctrl

Windowed envelope classifier and scheduler for the AM/ASK demodulation path. It consumes the FIR envelope stream and runs a two-window measurement sequence: acquire extremes, then classify. It publishes the decided modulation mode (NONE/AM/ASK) and the envelope extremes so the integration top can steer the demodulator output and decision thresholds. It sits between the envelope FIR output and the mode-select mux of the integrated automatic demodulator.

## Interface
- ENV_W, 14: envelope sample width (signed two's complement).
- WIN_LOG2, 10: window length is 2^WIN_LOG2 accepted samples.
- SIG_THRESH, 64: minimum window max for a signal to be present.
- MID_SHIFT, 3: ASK if mid-band count < 2^WIN_LOG2 >> MID_SHIFT.

- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin one measurement sequence; honoured only in IDLE.
- auto_run  in  1  when high, restart ACQ immediately after each decision.
- abort  in  1  return to IDLE from any state; results untouched.
- env_valid  in  1  env_in qualifier; counters advance only when high.
- env_in  in  ENV_W  signed envelope sample; negative values clamp to 0.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a decision is registered.
- mode  out  2  0 NONE, 1 AM, 2 ASK; 3 unused. Holds until the next decision.
- mode_valid  out  1  set by the first decision; cleared only by reset.
- env_max  out  ENV_W  maximum from the last completed ACQ window.
- env_min  out  ENV_W  minimum from the last completed ACQ window.

## Operation
- Each env_in sample is converted to an unsigned magnitude x = max(env_in, 0).
- States and transitions:
  - IDLE -> ACQ on start or auto_run.
  - ACQ -> THR after 2^WIN_LOG2 valid samples.
  - THR -> CLS after one cycle.
  - CLS -> DECIDE after 2^WIN_LOG2 valid samples.
  - DECIDE -> ACQ if auto_run is high, else IDLE.
- ACQ:
  - The first valid sample loads both max and min.
  - Each later valid sample updates max and min.
- THR computes:
  - q = (max − min) >> 2
  - lo = min + q
  - hi = max − q
  - All THR arithmetic is unsigned ENV_W, with no overflow possible.
- CLS:
  - mid_cnt (WIN_LOG2+1 bits) increments on each valid sample with lo < x < hi (strict inequality).
  - Samples equal to lo or hi do not count.
- DECIDE, evaluated in priority order:
  - max < SIG_THRESH -> NONE.
  - Else mid_cnt < (2^WIN_LOG2 >> MID_SHIFT) -> ASK.
  - Else AM.
- Registering a decision updates mode, env_max, env_min and mode_valid together.
- Boundary rules:
  - max == min gives q = 0 and lo == hi, so mid_cnt = 0; the result is ASK unless NONE applies.
  - start while busy is ignored.
  - abort has priority over every transition, including start in the same cycle. On abort, counters clear and mode, env_max, env_min and mode_valid keep their previous values.
  - env_valid gaps stall ACQ/CLS without losing any state.
  - Reset in any state has identical effect to power-up reset.

## Timing
- Reset values:
  - state = IDLE
  - busy = 0, done = 0
  - mode = 0, mode_valid = 0
  - env_max = 0, env_min = 0
  - all counters = 0
- Latency:
  - Edge k captures the final CLS sample, and state becomes DECIDE.
  - At edge k+1, mode, done = 1 and the extremes are registered.
  - done falls at edge k+2.
- auto_run: the first ACQ sample may be accepted on the cycle after DECIDE.
- Minimum sequence length is 2·2^WIN_LOG2 + 2 cycles with env_valid held high.
- busy rises at the edge that accepts start; it falls at the edge leaving DECIDE to IDLE.

## Structure
- Package demod_pkg holds:
  - mode enum (MODE_NONE, MODE_AM, MODE_ASK)
  - state enum (S_IDLE, S_ACQ, S_THR, S_CLS, S_DECIDE)
  - width constants shared with the AM/ASK path
- One sub-module, win_minmax, holds the clamp plus running max/min with a load-first control. It is reusable by the later FSK/PSK detectors.
- The FSM, window counter, threshold registers and mid counter stay in demod_window_ctrl.

## Test plan
All scenarios use WIN_LOG2=4, so a window is 16 samples and the ASK limit is 2.
- Reset check: assert rst_n=0 for 3 cycles mid-CLS. Required: all outputs return to reset values and state is IDLE.
- Square envelope alternating 0/1000, start pulse. Required:
  - env_max = 1000, env_min = 0, lo = 250, hi = 750, mid_cnt = 0
  - mode = ASK, done pulse 1 cycle, busy low after.
- Ramp 0,100,…,1500 in both windows. Required:
  - lo = 375, hi = 1125, mid_cnt = 8 (values 400..1100)
  - mode = AM.
- Constant 40, then constant −200 (clamped to 0). Required: mode = NONE in both cases, because max < 64.
- Handshake and abort:
  - Toggle env_valid every other cycle. Required: decision identical to the gap-free run, taking twice as long.
  - Assert abort mid-CLS. Required: IDLE next cycle, mode unchanged, no done pulse.
  - Pulse start while busy. Required: ignored.
- Continuous run: hold auto_run = 1 with ASK data, then AM data. Required:
  - Consecutive done pulses exactly 34 cycles apart.
  - mode switches ASK -> AM on the first decision whose ACQ window contains only AM data.
